// File: rtl/traffic_phase_timer.sv
// Four-phase two-way traffic sequencer with a per-second countdown of the current phase.
// Optional night flashing-yellow mode is compiled in with `define NIGHT_FLASH_EN.
module traffic_phase_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int GREEN_S  = 30,
  parameter int YELLOW_S = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       night,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] count_out,
  output logic [1:0] phase,
  output logic       sec_pulse
);

  generate
    if (TICK_DIV < 2 || GREEN_S < 1 || GREEN_S > 99 || YELLOW_S < 1 || YELLOW_S > 99) begin : g_bad_param
      $error("traffic_phase_timer: TICK_DIV must be >= 2, GREEN_S and YELLOW_S must be 1..99");
    end
  endgenerate

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_MAX    = PW'(TICK_DIV - 1);
  localparam logic [7:0]      GREEN_CNT  = 8'(GREEN_S);
  localparam logic [7:0]      YELLOW_CNT = 8'(YELLOW_S);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

`ifdef NIGHT_FLASH_EN
  // FLASH shares phase code 0 with NS_GO through the dropped top bit.
  typedef enum logic [2:0] {
    NS_GO = 3'd0, NS_SLOW = 3'd1, EW_GO = 3'd2, EW_SLOW = 3'd3, FLASH = 3'd4
  } state_t;
  logic flash_on;
`else
  typedef enum logic [1:0] {
    NS_GO = 2'd0, NS_SLOW = 2'd1, EW_GO = 2'd2, EW_SLOW = 2'd3
  } state_t;
  logic unused_night;
  assign unused_night = night;
`endif

  state_t        state;
  logic [PW-1:0] pre;

  assign sec_pulse = (pre == PRE_MAX) && en;
  assign phase     = state[1:0];

  // NOTE: every register below uses non-blocking assignment so all state
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre       <= '0;
      state     <= NS_GO;
      count_out <= GREEN_CNT;
`ifdef NIGHT_FLASH_EN
      flash_on  <= 1'b0;
    end else if (night) begin
      if (state != FLASH) begin
        state     <= FLASH;
        pre       <= '0;
        count_out <= 8'd0;
        flash_on  <= 1'b1;
      end else if (en) begin
        pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
        if (sec_pulse) flash_on <= ~flash_on;
      end
    end else if (state == FLASH) begin
      state     <= NS_GO;
      pre       <= '0;
      count_out <= GREEN_CNT;
      flash_on  <= 1'b0;
`endif
    end else if (en) begin
      pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
      if (sec_pulse) begin
        // Advancing on 1 rather than 0 keeps 0 off the display in normal phases.
        if (count_out == 8'd1) begin
          unique case (state)
            NS_GO:   begin state <= NS_SLOW; count_out <= YELLOW_CNT; end
            NS_SLOW: begin state <= EW_GO;   count_out <= GREEN_CNT;  end
            EW_GO:   begin state <= EW_SLOW; count_out <= YELLOW_CNT; end
            default: begin state <= NS_GO;   count_out <= GREEN_CNT;  end
          endcase
        end else begin
          count_out <= count_out - 8'd1;
        end
      end
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    case (state)
      NS_GO:   ns_light = LAMP_GREEN;
      NS_SLOW: ns_light = LAMP_YELLOW;
      EW_GO:   ew_light = LAMP_GREEN;
      EW_SLOW: ew_light = LAMP_YELLOW;
`ifdef NIGHT_FLASH_EN
      FLASH: begin
        ns_light = flash_on ? LAMP_YELLOW : LAMP_OFF;
        ew_light = flash_on ? LAMP_YELLOW : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Self-checking bench for traffic_phase_timer (TICK_DIV=4, GREEN_S=5, YELLOW_S=2):
// an arithmetic reference model pushes expected outputs to a scoreboard each cycle.
module tb_traffic_phase_timer;

  localparam int TD    = 4;
  localparam int G     = 5;
  localparam int Y     = 2;
  localparam int CYC_S = 2 * (G + Y);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       night = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic [7:0] count_out;
  logic [1:0] phase;
  logic       sec_pulse;

  traffic_phase_timer #(.TICK_DIV(TD), .GREEN_S(G), .YELLOW_S(Y)) dut (
    .clk(clk), .rst(rst), .en(en), .night(night),
    .ns_light(ns_light), .ew_light(ew_light), .count_out(count_out),
    .phase(phase), .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic [7:0] cnt;
    logic [1:0] ph;
    logic       sp;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  // Reference model state: enabled cycles since cycle start, plus flash bookkeeping.
  int t = 0;
  bit in_flash = 0;
  int fpre = 0;
  bit fon = 0;

  function automatic exp_t model_out(input logic en_v);
    exp_t e;
    int pos, s;
    if (in_flash) begin
      e.ph  = 2'd0;
      e.cnt = 8'd0;
      e.ns  = fon ? 3'b010 : 3'b000;
      e.ew  = fon ? 3'b010 : 3'b000;
      e.sp  = en_v && (fpre == TD - 1);
      return e;
    end
    pos  = t % (CYC_S * TD);
    s    = pos / TD;
    e.sp = en_v && ((pos % TD) == TD - 1);
    if (s < G) begin
      e.ph = 2'd0; e.cnt = 8'(G - s); e.ns = 3'b001; e.ew = 3'b100;
    end else if (s < G + Y) begin
      e.ph = 2'd1; e.cnt = 8'(G + Y - s); e.ns = 3'b010; e.ew = 3'b100;
    end else if (s < 2 * G + Y) begin
      e.ph = 2'd2; e.cnt = 8'(2 * G + Y - s); e.ns = 3'b100; e.ew = 3'b001;
    end else begin
      e.ph = 2'd3; e.cnt = 8'(CYC_S - s); e.ns = 3'b100; e.ew = 3'b010;
    end
    return e;
  endfunction

  task automatic model_edge(input logic rst_v, input logic en_v, input logic night_v);
    if (rst_v) begin
      t = 0; in_flash = 0; fpre = 0; fon = 0;
`ifdef NIGHT_FLASH_EN
    end else if (night_v) begin
      if (!in_flash) begin
        in_flash = 1; fpre = 0; fon = 1;
      end else if (en_v) begin
        if (fpre == TD - 1) fon = ~fon;
        fpre = (fpre + 1) % TD;
      end
    end else if (in_flash) begin
      in_flash = 0; t = 0;
`endif
    end else if (en_v) begin
      t++;
    end
  endtask

  // Drive one cycle, push the model's post-edge expectation, then pop and compare.
  task automatic step(input logic rst_v, input logic en_v, input logic night_v, input string tag);
    exp_t e;
    rst = rst_v; en = en_v; night = night_v;
    model_edge(rst_v, en_v, night_v);
    sb.push_back(model_out(en_v));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_run++;
    if (count_out !== e.cnt || phase !== e.ph || ns_light !== e.ns ||
        ew_light !== e.ew || sec_pulse !== e.sp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got cnt=%0d ph=%0d ns=%b ew=%b sp=%b, want cnt=%0d ph=%0d ns=%b ew=%b sp=%b",
               tag, t, count_out, phase, ns_light, ew_light, sec_pulse,
               e.cnt, e.ph, e.ns, e.ew, e.sp);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "reset");
    n_run++;
    if (count_out !== 8'd5 || phase !== 2'd0 || ns_light !== 3'b001 ||
        ew_light !== 3'b100 || sec_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got cnt=%0d ph=%0d ns=%b ew=%b sp=%b, want 5 0 001 100 0",
               count_out, phase, ns_light, ew_light, sec_pulse);
    end
  endtask

  task automatic test_full_cycle();
    step(1'b1, 1'b0, 1'b0, "cycle_rst");
    for (int i = 1; i <= 56; i++) begin
      step(1'b0, 1'b1, 1'b0, "full_cycle");
      if (i == 3) begin
        n_run++;
        if (sec_pulse !== 1'b1) begin
          n_fail++;
          $display("FAIL first_pulse: got sec_pulse=%b, want 1", sec_pulse);
        end
      end
    end
    n_run++;
    if (count_out !== 8'd5 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL cycle_wrap: got cnt=%0d ph=%0d, want 5 0", count_out, phase);
    end
  endtask

  task automatic test_pause();
    step(1'b1, 1'b0, 1'b0, "pause_rst");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, "pause_pre");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, "pause_hold");
      n_run++;
      if (count_out !== 8'd4 || sec_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold: got cnt=%0d sp=%b, want 4 0", count_out, sec_pulse);
      end
    end
    step(1'b0, 1'b1, 1'b0, "pause_resume1");
    step(1'b0, 1'b1, 1'b0, "pause_resume2");
    n_run++;
    if (count_out !== 8'd3) begin
      n_fail++;
      $display("FAIL pause_resume: got cnt=%0d, want 3", count_out);
    end
  endtask

  task automatic test_reset_mid_phase();
    step(1'b1, 1'b0, 1'b0, "mid_rst");
    for (int i = 0; i < 53; i++) step(1'b0, 1'b1, 1'b0, "to_ew_slow");
    n_run++;
    if (phase !== 2'd3 || count_out !== 8'd1) begin
      n_fail++;
      $display("FAIL ew_slow_reached: got ph=%0d cnt=%0d, want 3 1", phase, count_out);
    end
    step(1'b1, 1'b1, 1'b0, "mid_reset");
    n_run++;
    if (ns_light !== 3'b001 || ew_light !== 3'b100 || count_out !== 8'd5) begin
      n_fail++;
      $display("FAIL mid_reset: got ns=%b ew=%b cnt=%0d, want 001 100 5", ns_light, ew_light, count_out);
    end
  endtask

  task automatic test_night();
    step(1'b1, 1'b0, 1'b0, "night_rst");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, "night_pre");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, "night_on");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, "night_paused");
    step(1'b0, 1'b1, 1'b0, "night_exit");
`ifdef NIGHT_FLASH_EN
    n_run++;
    if (count_out !== 8'd5 || phase !== 2'd0 || ns_light !== 3'b001) begin
      n_fail++;
      $display("FAIL night_exit: got cnt=%0d ph=%0d ns=%b, want 5 0 001", count_out, phase, ns_light);
    end
`endif
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, "night_after");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b0, "b2b_rst");
    for (int i = 0; i < 120; i++)
      step(1'b0, ($urandom_range(0, 3) != 0), 1'b0, "b2b_random_en");
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_pause();
    test_reset_mid_phase();
    test_night();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
